// File: rtl/clip_bank_pkg.sv
// Shared types for the clip bank record/playback sequencer.
// Command decoding lives here so every user agrees on the same priority order.
package clip_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FETCH  = 2'd2,
    HOLD   = 2'd3
  } clip_state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_RECORD,
    CMD_PLAY
  } clip_cmd_e;

  // Bit positions in the packed command vector, highest index wins.
  localparam int CMD_W          = 3;
  localparam int CMD_STOP_BIT   = 2;
  localparam int CMD_RECORD_BIT = 1;
  localparam int CMD_PLAY_BIT   = 0;

  function automatic clip_cmd_e decode_cmd(input logic [CMD_W-1:0] cmds);
    if (cmds[CMD_STOP_BIT])        return CMD_STOP;
    else if (cmds[CMD_RECORD_BIT]) return CMD_RECORD;
    else if (cmds[CMD_PLAY_BIT])   return CMD_PLAY;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/clip_length_table.sv
// Per-clip recorded-length registers (ADDR_W+1 bits so a full clip is representable).
// One clear port, one increment port, one read port and a nonzero vector.
module clip_length_table
  import clip_bank_pkg::*;
#(
  parameter int NUM_CLIPS = 4,
  parameter int ADDR_W    = 16,
  localparam int SEL_W    = $clog2(NUM_CLIPS),
  localparam int LEN_W    = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_en,
  input  logic [SEL_W-1:0]     clr_sel,
  input  logic                 inc_en,
  input  logic [SEL_W-1:0]     inc_sel,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [LEN_W-1:0]     rd_len,
  output logic [NUM_CLIPS-1:0] nonzero
);

  logic [LEN_W-1:0] len_all [NUM_CLIPS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIPS; gi++) begin : g_len
      logic [LEN_W-1:0] len_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          len_reg <= '0;
        end else if (clr_en && clr_sel == SEL_W'(gi)) begin
          len_reg <= '0;
        end else if (inc_en && inc_sel == SEL_W'(gi)) begin
          len_reg <= len_reg + LEN_W'(1);
        end
      end

      assign len_all[gi] = len_reg;
      assign nonzero[gi] = |len_reg;
    end
  endgenerate

  assign rd_len = len_all[rd_sel];

endmodule

// File: rtl/clip_bank_controller.sv
// Record/playback sequencer over NUM_CLIPS single-port clip banks with
// per-clip length tracking, looping playback and a valid/ready sample output.
module clip_bank_controller
  import clip_bank_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int NUM_CLIPS = 4,
  localparam int SEL_W    = $clog2(NUM_CLIPS)
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        play_i,
  input  logic                        record_i,
  input  logic                        stop_i,
  input  logic                        loop_i,
  input  logic [SEL_W-1:0]            play_clip_i,
  input  logic [SEL_W-1:0]            record_clip_i,
  input  logic                        in_valid_i,
  input  logic [DATA_W-1:0]           in_data_i,
  input  logic                        out_ready_i,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [NUM_CLIPS-1:0]        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [NUM_CLIPS*DATA_W-1:0] mem_rdata_i,
  output logic [1:0]                  state_o,
  output logic [SEL_W-1:0]            active_clip_o,
  output logic [NUM_CLIPS-1:0]        clip_full_o
);

  localparam int LEN_W = ADDR_W + 1;

  clip_state_e       state_reg, state_next;
  logic [SEL_W-1:0]  active_clip_reg, active_clip_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg;
  logic              fresh_reg;
  clip_cmd_e         cmd;
  logic [LEN_W-1:0]  rd_len;
  logic              last_sample;
  logic              len_clr, len_inc;
  logic [SEL_W-1:0]  rd_sel;
  logic [DATA_W-1:0] bank_rdata [NUM_CLIPS];

  assign cmd = decode_cmd({stop_i, record_i, play_i});

  assign len_clr = (state_reg == IDLE) && (cmd == CMD_RECORD);
  assign len_inc = (state_reg == RECORD) && in_valid_i;
  assign rd_sel  = (state_reg == IDLE) ? play_clip_i : active_clip_reg;

  clip_length_table #(
    .NUM_CLIPS (NUM_CLIPS),
    .ADDR_W    (ADDR_W)
  ) u_len (
    .clk     (clock_i),
    .rst     (reset_i),
    .clr_en  (len_clr),
    .clr_sel (record_clip_i),
    .inc_en  (len_inc),
    .inc_sel (active_clip_reg),
    .rd_sel  (rd_sel),
    .rd_len  (rd_len),
    .nonzero (clip_full_o)
  );

  assign last_sample = ({1'b0, addr_reg} == (rd_len - LEN_W'(1)));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIPS; gi++) begin : g_bank
      assign bank_rdata[gi] = mem_rdata_i[gi*DATA_W +: DATA_W];
      assign mem_en_o[gi]   = (state_reg != IDLE) && (active_clip_reg == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    active_clip_next = active_clip_reg;
    addr_next        = addr_reg;
    case (state_reg)
      IDLE: begin
        case (cmd)
          CMD_RECORD: begin
            state_next       = RECORD;
            active_clip_next = record_clip_i;
            addr_next        = '0;
          end
          CMD_PLAY: begin
            if (rd_len != '0) begin
              state_next       = FETCH;
              active_clip_next = play_clip_i;
              addr_next        = '0;
            end
          end
          default: ;
        endcase
      end
      RECORD: begin
        if (in_valid_i) begin
          // The final address fills the clip; stop rather than wrap.
          if (addr_reg == {ADDR_W{1'b1}}) begin
            state_next = IDLE;
            addr_next  = '0;
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
          end
        end
        if (stop_i) begin
          state_next = IDLE;
          addr_next  = '0;
        end
      end
      FETCH: begin
        state_next = stop_i ? IDLE : HOLD;
        if (stop_i) addr_next = '0;
      end
      HOLD: begin
        if (stop_i) begin
          state_next = IDLE;
          addr_next  = '0;
        end else if (out_ready_i) begin
          if (!last_sample) begin
            state_next = FETCH;
            addr_next  = addr_reg + ADDR_W'(1);
          end else if (loop_i) begin
            state_next = FETCH;
            addr_next  = '0;
          end else begin
            state_next = IDLE;
            addr_next  = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      active_clip_reg <= '0;
      addr_reg        <= '0;
      fresh_reg       <= 1'b0;
      data_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      active_clip_reg <= active_clip_next;
      addr_reg        <= addr_next;
      fresh_reg       <= (state_reg == FETCH) && (state_next == HOLD);
      if (fresh_reg) data_reg <= bank_rdata[active_clip_reg];
    end
  end

  // Bank data arrives during the first HOLD cycle; it is latched there for the rest of HOLD.
  assign out_data_o    = fresh_reg ? bank_rdata[active_clip_reg] : data_reg;
  assign out_valid_o   = (state_reg == HOLD);
  assign mem_we_o      = (state_reg == RECORD) && in_valid_i;
  assign mem_wdata_o   = in_data_i;
  assign mem_addr_o    = addr_reg;
  assign state_o       = state_reg;
  assign active_clip_o = active_clip_reg;

endmodule

// File: doc/clip_bank_controller.md
# clip_bank_controller

Parametrised record/playback sequencer for the audio path. Sits between the synchronised user commands, the PDM deserializer's sample output, the PWM serializer's sample input and a set of `NUM_CLIPS` single-port block-RAM clip banks. Generalises the two-bank controller:
- N clips
- per-clip recorded-length tracking
- looping playback
- explicit stop
- a valid/ready sample handshake to the serializer

## Interface
- `DATA_W`, 16: sample width.
- `ADDR_W`, 16: clip address width; clip capacity is `2**ADDR_W` samples.
- `NUM_CLIPS`, 4: number of clip banks, ≥2.
- `SEL_W` (localparam): `$clog2(NUM_CLIPS)`.

Ports:
- `clock_i` in 1: 100 MHz clock; the only clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `play_i`, `record_i`, `stop_i` in 1 each: one-cycle command pulses, already synchronised.
- `loop_i` in 1: level; sampled at each end-of-clip.
- `play_clip_i`, `record_clip_i` in `SEL_W`: clip selects, sampled at command accept.
- `in_valid_i` in 1, `in_data_i` in `DATA_W`: deserializer sample strobe/data.
- `out_ready_i` in 1: serializer accepts sample.
- `out_valid_o` out 1, `out_data_o` out `DATA_W`: playback sample.
- `mem_en_o` out `NUM_CLIPS`: one-hot bank enable.
- `mem_we_o` out 1, `mem_addr_o` out `ADDR_W`, `mem_wdata_o` out `DATA_W`: shared bank bus.
- `mem_rdata_i` in `NUM_CLIPS*DATA_W`: bank read data; bank k occupies bits `[k*DATA_W +: DATA_W]`.
- `state_o` out 2, `active_clip_o` out `SEL_W`, `clip_full_o` out `NUM_CLIPS`: status for the LED driver. `clip_full_o[k]` means clip k has length > 0.

## Operation
- States:
  - `IDLE` = 0
  - `RECORD` = 1
  - `FETCH` = 2: read address issued to the bank.
  - `HOLD` = 3: sample presented, awaiting `out_ready_i`.
- Command priority, same cycle: `stop_i` > `record_i` > `play_i`.
- In `IDLE`:
  - `record_i` → `RECORD`:
    - `active_clip` = `record_clip_i`
    - addr = 0
    - `len[clip]` = 0, so that clip's `clip_full_o` bit clears.
  - `play_i` with `len[play_clip_i]` > 0 → `FETCH`; `active_clip` = `play_clip_i`, addr = 0.
  - `play_i` on an empty clip is ignored.
  - `stop_i` is a no-op.
- In any non-IDLE state:
  - `record_i` and `play_i` are ignored.
  - `stop_i` → `IDLE` next cycle.
- `RECORD`:
  - Each `in_valid_i` cycle writes `in_data_i` at addr, then addr++ and `len++`.
  - The write of sample index `2**ADDR_W-1` fills the clip: `len` = `2**ADDR_W`, next state `IDLE`, further samples dropped.
  - `stop_i` ends recording. `len` keeps the count of samples written so far. If `stop_i` and `in_valid_i` coincide, that sample is written and counted.
- `FETCH` → `HOLD` unconditionally. On entry to `HOLD`, `out_data_o` captures bank `active_clip` read data.
- `HOLD`: `out_valid_o` = 1 and data stays stable until `out_valid_o && out_ready_i`. On that handshake:
  - addr < `len-1` → addr++, `FETCH`.
  - Last sample and `loop_i`=1 → addr = 0, `FETCH`.
  - Last sample and `loop_i`=0 → `IDLE`.
- Lengths are stored on `ADDR_W+1` bits. Address increments never wrap silently; the only wrap is the loop restart to 0.
- Reset mid-operation aborts the operation. All lengths clear, so every clip becomes empty.

## Timing
- Reset values:
  - State `IDLE`; `state_o`=0, `active_clip_o`=0, `clip_full_o`=0.
  - `out_valid_o`=0, `out_data_o`=0.
  - `mem_addr_o`=0, `mem_en_o`=0, `mem_we_o`=0.
  - All `len` = 0.
- `mem_addr_o` is registered.
- `mem_en_o` = onehot(`active_clip`) whenever state ≠ `IDLE`, else 0.
- `mem_we_o` = (state==`RECORD`) && `in_valid_i`, combinational. `mem_wdata_o` = `in_data_i`, combinational. The write lands at that clock edge.
- Bank read latency is 1 cycle. `FETCH` covers it: `out_valid_o` rises 2 cycles after play is accepted.
- Maximum playback throughput is 1 sample per 2 cycles.
- `clip_full_o` and `len` update on the cycle after the triggering event.
- After `stop_i` in `HOLD`, `out_valid_o` is 0 on the next cycle.

## Structure
- Package `clip_bank_pkg`:
  - `typedef enum logic [1:0] clip_state_e`: `IDLE`, `RECORD`, `FETCH`, `HOLD`.
  - Command-priority localparams.
- One sub-module: `clip_length_table`.
  - Holds `NUM_CLIPS` × (`ADDR_W+1`) length registers.
  - Ports: clear-one, increment-one, read-one, `nonzero` vector.
  - Async reset clears all entries.

## Test plan
- Use `ADDR_W=4` throughout.
- Record 5 samples (0x1111..0x5555) into clip 2, then `stop_i`:
  - 5 writes to addr 0..4 with `mem_en_o`=4'b0100.
  - `clip_full_o`=4'b0100.
- Play clip 2, `loop_i`=0, `out_ready_i` held high:
  - `out_data_o` sequence is 0x1111..0x5555.
  - `out_valid_o` first rises 2 cycles after `play_i`.
  - Returns to `IDLE` after the 5th handshake.
- Play clip 2 with `loop_i`=1 and `out_ready_i` toggling:
  - Each sample is held until ready.
  - The sample after 0x5555 is 0x1111.
  - `stop_i` gives `IDLE` with `out_valid_o`=0 next cycle.
- Record 20 valid samples into clip 0:
  - Exactly 16 are written.
  - `len`=16 and auto-return to `IDLE`.
  - Samples 17..20 are never written.
- `play_i` on empty clip 1 → stays in `IDLE`. Same-cycle `record_i`+`play_i` → `RECORD`.
- Assert `reset_i` mid-`RECORD`:
  - All outputs go to reset values immediately.
  - `clip_full_o`=0.
  - A subsequent play of that clip is ignored.
